// File: rtl/pulse_stretcher.sv
// ============================================================================
// pulse_stretcher: turns single-cycle event strobes into fixed on/off LED
// blinks, queueing overlapping events in a saturating pending counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_stretcher #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int PEND_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic cnt_zero;
  logic start_next;
  logic pend_dec;

  assign cnt_zero   = (cnt == '0);
  // A pulse arriving in the final OFF cycle counts toward starting the next blink.
  assign start_next = (pending != '0) || pulse_in;
  assign pend_dec   = (state == OFF) && cnt_zero && start_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      led_out  <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse_in) begin
            state   <= ON;
            cnt     <= ON_LOAD;
            led_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ON: begin
          if (cnt_zero) begin
            state   <= OFF;
            cnt     <= OFF_LOAD;
            led_out <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OFF: begin
          if (cnt_zero) begin
            if (start_next) begin
              state   <= ON;
              cnt     <= ON_LOAD;
              led_out <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          led_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase

      // An IDLE pulse starts a blink directly and never touches the queue.
      if (state != IDLE) begin
        if (pulse_in && !pend_dec) begin
          if (pending == PEND_MAX) begin
            overflow <= 1'b1;
          end else begin
            pending <= pending + 1'b1;
          end
        end else if (!pulse_in && pend_dec) begin
          pending <= pending - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ============================================================================
// tb_pulse_stretcher: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a blink-schedule model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pulse_stretcher;

  localparam int ON_CYCLES  = 4;
  localparam int OFF_CYCLES = 2;
  localparam int PEND_W     = 2;
  localparam int PMAX       = (1 << PEND_W) - 1;

  logic              clk;
  logic              rst;
  logic              pulse_in;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  pulse_stretcher #(
    .ON_CYCLES (ON_CYCLES),
    .OFF_CYCLES(OFF_CYCLES),
    .PEND_W    (PEND_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int cyc, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // Model: a blink started at cycle s lights cycles s..s+ON-1, is dark until
  // s+ON+OFF-1, and at cycle s+ON+OFF the next queued event (if any) starts.
  bit model_on = 0;
  bit m_act    = 0;
  int m_start  = 0;
  int m_pend   = 0;
  bit m_ovf    = 0;
  int mc       = 0;

  always @(posedge clk) begin
    automatic bit p = pulse_in;
    automatic bit r = rst;
    automatic int eff;
    #1;
    mc++;
    if (r) begin
      m_act    = 0;
      m_pend   = 0;
      m_ovf    = 0;
      model_on = 1;
    end else if (!m_act) begin
      if (p) begin
        m_act   = 1;
        m_start = mc;
      end
    end else if (mc - m_start == ON_CYCLES + OFF_CYCLES) begin
      eff = m_pend + int'(p);
      if (eff > 0) begin
        m_start = mc;
        m_pend  = eff - 1;
      end else begin
        m_act = 0;
      end
    end else if (p) begin
      if (m_pend == PMAX) m_ovf = 1;
      else m_pend++;
    end
    if (model_on) begin
      check("model_led",      mc, int'(led_out),  int'(m_act && (mc - m_start < ON_CYCLES)));
      check("model_busy",     mc, int'(busy),     int'(m_act));
      check("model_pending",  mc, int'(pending),  m_pend);
      check("model_overflow", mc, int'(overflow), int'(m_ovf));
    end
  end

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [39:0] rng(input int a, input int b);
    logic [39:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic run_scenario(input int sc, input logic [39:0] pmask, input logic [39:0] rmask,
                              input logic [39:0] led_exp, input logic [39:0] busy_exp);
    rst      = 1'b1;
    pulse_in = 1'b0;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 40; t++) begin
      check($sformatf("s%0d_led", sc),  t, int'(led_out), int'(led_exp[t]));
      check($sformatf("s%0d_busy", sc), t, int'(busy),    int'(busy_exp[t]));
      if (sc == 1 && t == 0) begin
        check("reset_pending",  t, int'(pending),  0);
        check("reset_overflow", t, int'(overflow), 0);
      end
      if (sc == 2 && t == 12) check("s2_pending12", t, int'(pending), 1);
      if (sc == 2 && t == 13) check("s2_pending13", t, int'(pending), 2);
      if (sc == 2 && t == 23) check("s2_pending23", t, int'(pending), 0);
      if (sc == 3 && t == 17) check("s3_pending17", t, int'(pending), 0);
      if (sc == 4 && t == 14) check("s4_pending14", t, int'(pending), 3);
      if (sc == 4 && t == 14) check("s4_overflow14", t, int'(overflow), 0);
      if (sc == 4 && t == 15) check("s4_overflow15", t, int'(overflow), 1);
      if (sc == 4 && t == 39) check("s4_overflow39", t, int'(overflow), 1);
      if (sc == 5 && t == 14) begin
        check("s5_pending14",  t, int'(pending),  0);
        check("s5_overflow14", t, int'(overflow), 0);
      end
      pulse_in = pmask[t];
      rst      = rmask[t];
      tick();
    end
    rst      = 1'b0;
    pulse_in = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    pulse_in = 1'b0;
    tick();

    run_scenario(1, rng(10, 10), '0, rng(11, 14), rng(11, 16));
    run_scenario(2, rng(10, 12), '0, rng(11, 14) | rng(17, 20) | rng(23, 26), rng(11, 28));
    run_scenario(3, rng(10, 10) | rng(16, 16), '0, rng(11, 14) | rng(17, 20), rng(11, 22));
    run_scenario(4, rng(10, 14), '0,
                 rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32), rng(11, 34));
    run_scenario(5, rng(10, 11) | rng(20, 20), rng(13, 13),
                 rng(11, 13) | rng(21, 24), rng(11, 13) | rng(21, 26));
    run_scenario(6, rng(10, 10), rng(10, 10), '0, '0);

    // Randomized traffic: sparse pulses, occasional bursts, rare resets.
    for (int i = 0; i < 4000; i++) begin
      automatic int sel = int'($urandom_range(0, 99));
      if (i % 400 < 60) pulse_in = (sel < 70);
      else              pulse_in = (sel < 15);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst      = 1'b0;
    pulse_in = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
